// File: rtl/emu_time_mgr_pkg.sv
// emu_time_mgr_pkg: shared types and helpers for the emulation time manager.
//   state_e      run-control FSM states (HALT / RUN / STOPPED)
//   STATE_W      encoding width of state_e
//   sat_narrow() saturating narrow of a time-domain value to a grant width
// Also supplies a default for the `DT_WIDTH macro when the build does not set it.
`ifndef DT_WIDTH
`define DT_WIDTH 16
`endif

package emu_time_mgr_pkg;

  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    ST_HALT    = 2'd0,
    ST_RUN     = 2'd1,
    ST_STOPPED = 2'd2
  } state_e;

  // Clamp v to 2^w - 1. Carried in 64 bits (TIME_WIDTH is capped at 64);
  // the caller truncates the result to its own grant width.
  function automatic logic [63:0] sat_narrow(input logic [63:0] v, input int unsigned w);
    logic [63:0] lim;
    lim = (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
    return (v > lim) ? lim : v;
  endfunction

endpackage

// File: rtl/emu_time_mgr_if.sv
// emu_time_mgr_if: timestep request/grant bus between the oscillator/event
// models and the time manager.
//   emu_dt_req  flattened requests, requester i at [i*DT_WIDTH +: DT_WIDTH]
//   req_active  per-requester enable
//   emu_dt      granted timestep (combinational, same cycle)
//   emu_time    registered global emulation time
// Modports: master = requester side, slave = time manager.
`ifndef DT_WIDTH
`define DT_WIDTH 16
`endif

interface emu_time_mgr_if #(
  parameter int N_REQ      = 2,
  parameter int DT_WIDTH   = `DT_WIDTH,
  parameter int TIME_WIDTH = 64
) ();
  logic [N_REQ*DT_WIDTH-1:0] emu_dt_req;
  logic [N_REQ-1:0]          req_active;
  logic [DT_WIDTH-1:0]       emu_dt;
  logic [TIME_WIDTH-1:0]     emu_time;

  modport master (output emu_dt_req, output req_active, input emu_dt, input emu_time);
  modport slave  (input emu_dt_req, input req_active, output emu_dt, output emu_time);
endinterface

// File: rtl/emu_time_mgr_dt_min_tree.sv
// dt_min_tree: combinational balanced-binary minimum over N_REQ requests.
//   dt_req      flattened requests
//   req_active  per-request enable; inactive leaves read as all-ones
//   dt_min      unsigned minimum of active requests (all-ones if none)
//   any_active  at least one request enabled
// Leaves are padded up to a power of two with all-ones so every level halves.
module dt_min_tree #(
  parameter int N_REQ    = 2,
  parameter int DT_WIDTH = 16
) (
  input  logic [N_REQ*DT_WIDTH-1:0] dt_req,
  input  logic [N_REQ-1:0]          req_active,
  output logic [DT_WIDTH-1:0]       dt_min,
  output logic                      any_active
);
  localparam int LEVELS = (N_REQ > 1) ? $clog2(N_REQ) : 0;
  localparam int NP     = 1 << LEVELS;

  for (genvar l = 0; l <= LEVELS; l++) begin : g_lvl
    logic [(NP>>l)-1:0][DT_WIDTH-1:0] v;
    if (l == 0) begin : g_leaf
      for (genvar i = 0; i < NP; i++) begin : g_i
        if (i < N_REQ) begin : g_real
          assign v[i] = req_active[i] ? dt_req[i*DT_WIDTH +: DT_WIDTH] : '1;
        end else begin : g_pad
          assign v[i] = '1;
        end
      end
    end else begin : g_node
      for (genvar i = 0; i < (NP>>l); i++) begin : g_i
        assign v[i] = (g_lvl[l-1].v[2*i] < g_lvl[l-1].v[2*i+1]) ?
                      g_lvl[l-1].v[2*i] : g_lvl[l-1].v[2*i+1];
      end
    end
  end

  assign dt_min     = g_lvl[LEVELS].v[0];
  assign any_active = |req_active;
endmodule

// File: rtl/emu_time_mgr.sv
// emu_time_mgr: responder side of the timestep request protocol. Grants the
// minimum active request (capped by the stop-time boundary) while running,
// owns the global emulation time and the HALT/RUN/STOPPED control FSM.
// Ports:
//   emu_clk, emu_rst  clock, synchronous active-high reset
//   bus               emu_time_mgr_if.slave (requests in, grant/time out)
//   go / halt         control pulses (halt has priority)
//   stop_en,stop_time absolute stop boundary
//   dt_limit          optional per-cycle grant cap, 0 = no limit
//                     (present only with EMU_TIME_MGR_DT_LIMIT_EN)
//   state             0 HALT, 1 RUN, 2 STOPPED
//   stop_hit          one-cycle pulse on RUN -> STOPPED
// TIME_WIDTH must satisfy DT_WIDTH <= TIME_WIDTH <= 64.
`ifndef DT_WIDTH
`define DT_WIDTH 16
`endif

module emu_time_mgr
  import emu_time_mgr_pkg::*;
#(
  parameter int N_REQ      = 2,
  parameter int DT_WIDTH   = `DT_WIDTH,
  parameter int TIME_WIDTH = 64
) (
  input  logic                  emu_clk,
  input  logic                  emu_rst,
  emu_time_mgr_if.slave         bus,
  input  logic                  go,
  input  logic                  halt,
  input  logic                  stop_en,
  input  logic [TIME_WIDTH-1:0] stop_time,
`ifdef EMU_TIME_MGR_DT_LIMIT_EN
  input  logic [DT_WIDTH-1:0]   dt_limit,
`endif
  output logic [STATE_W-1:0]    state,
  output logic                  stop_hit
);
  localparam logic [DT_WIDTH-1:0] DT_IDLE = {1'b1, {(DT_WIDTH-1){1'b0}}};

  state_e                state_q;
  logic                  stop_hit_q;
  logic [TIME_WIDTH-1:0] time_q;
  logic [TIME_WIDTH-1:0] time_gap;
  logic [DT_WIDTH-1:0]   tree_min, d_stop, dt_run, dt_grant;
  logic                  any_active;

  dt_min_tree #(.N_REQ(N_REQ), .DT_WIDTH(DT_WIDTH)) u_min (
    .dt_req     (bus.emu_dt_req),
    .req_active (bus.req_active),
    .dt_min     (tree_min),
    .any_active (any_active)
  );

  // Modular distance to the stop boundary; a stop_time behind us wraps to a
  // huge gap and saturates, so running continues until time wraps.
  assign time_gap = stop_time - time_q;
  assign d_stop   = DT_WIDTH'(sat_narrow(64'(time_gap), DT_WIDTH));

  // Grant path stays purely combinational: requesters compare against it
  // in the same cycle.
  always_comb begin
    dt_run = any_active ? tree_min : DT_IDLE;
    if (stop_en && (d_stop < dt_run)) dt_run = d_stop;
`ifdef EMU_TIME_MGR_DT_LIMIT_EN
    if ((dt_limit != '0) && (dt_limit < dt_run)) dt_run = dt_limit;
`endif
    dt_grant = (state_q == ST_RUN) ? dt_run : '0;
  end

  always_ff @(posedge emu_clk) begin
    if (emu_rst) begin
      state_q    <= ST_HALT;
      stop_hit_q <= 1'b0;
      time_q     <= '0;
    end else begin
      // Grant is already 0 outside RUN, so time freezes without a gate here.
      time_q     <= time_q + TIME_WIDTH'(dt_grant);
      stop_hit_q <= 1'b0;
      if (halt) begin
        state_q <= ST_HALT;
      end else begin
        case (state_q)
          ST_HALT, ST_STOPPED: if (go) state_q <= ST_RUN;
          ST_RUN: begin
            if (stop_en && (time_q == stop_time)) begin
              state_q    <= ST_STOPPED;
              stop_hit_q <= 1'b1;
            end
          end
          default: state_q <= ST_HALT;
        endcase
      end
    end
  end

  assign bus.emu_dt   = dt_grant;
  assign bus.emu_time = time_q;
  assign state        = state_q;
  assign stop_hit     = stop_hit_q;
endmodule

// File: tb/tb_emu_time_mgr.sv
// tb_emu_time_mgr: directed, table-driven bench for emu_time_mgr. Main DUT is
// N_REQ=2, DT_WIDTH=16, TIME_WIDTH=64; a second DUT with 8-bit time covers
// counter wrap. dt_limit is exercised when EMU_TIME_MGR_DT_LIMIT_EN is set.
module tb_emu_time_mgr;
  import emu_time_mgr_pkg::*;

  logic emu_clk = 1'b0;
  logic emu_rst = 1'b1;
  always #5 emu_clk = ~emu_clk;

  int n_tests = 0;
  int n_fail  = 0;

  // main DUT
  emu_time_mgr_if #(.N_REQ(2), .DT_WIDTH(16), .TIME_WIDTH(64)) bus ();
  logic        go, halt, stop_en, stop_hit;
  logic [63:0] stop_time;
  logic [1:0]  state;
`ifdef EMU_TIME_MGR_DT_LIMIT_EN
  logic [15:0] dt_limit;
`endif

  emu_time_mgr #(.N_REQ(2), .DT_WIDTH(16), .TIME_WIDTH(64)) dut (
    .emu_clk   (emu_clk),
    .emu_rst   (emu_rst),
    .bus       (bus),
    .go        (go),
    .halt      (halt),
    .stop_en   (stop_en),
    .stop_time (stop_time),
`ifdef EMU_TIME_MGR_DT_LIMIT_EN
    .dt_limit  (dt_limit),
`endif
    .state     (state),
    .stop_hit  (stop_hit)
  );

  // 8-bit time DUT for wrap
  emu_time_mgr_if #(.N_REQ(2), .DT_WIDTH(8), .TIME_WIDTH(8)) bus8 ();
  logic       go8, halt8, stop_en8, stop_hit8;
  logic [7:0] stop_time8;
  logic [1:0] state8;
`ifdef EMU_TIME_MGR_DT_LIMIT_EN
  logic [7:0] dt_limit8;
`endif

  emu_time_mgr #(.N_REQ(2), .DT_WIDTH(8), .TIME_WIDTH(8)) dut8 (
    .emu_clk   (emu_clk),
    .emu_rst   (emu_rst),
    .bus       (bus8),
    .go        (go8),
    .halt      (halt8),
    .stop_en   (stop_en8),
    .stop_time (stop_time8),
`ifdef EMU_TIME_MGR_DT_LIMIT_EN
    .dt_limit  (dt_limit8),
`endif
    .state     (state8),
    .stop_hit  (stop_hit8)
  );

  typedef struct {
    logic [1:0]  act;
    logic [15:0] r0, r1;
    logic        sen;
    logic [63:0] st;
    logic [63:0] dt;  // expected grant
    logic [63:0] tm;  // expected emu_time when applied
  } vec_t;

  vec_t vt [13];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge emu_clk);
    #1;
  endtask

  task automatic set_req(input logic [1:0] a, input logic [15:0] r0, input logic [15:0] r1);
    bus.req_active = a;
    bus.emu_dt_req = {r1, r0};
  endtask

  task automatic pulse_go;
    go = 1'b1;
    tick();
    go = 1'b0;
  endtask

  task automatic do_reset;
    emu_rst = 1'b1;
    tick();
    emu_rst = 1'b0;
  endtask

  initial begin
    //          act    r0   r1   sen  stop_time  dt     time
    vt[0]  = '{2'b11, 100,  40, 1'b0, 0,      40,     0};
    vt[1]  = '{2'b11, 100,  40, 1'b0, 0,      40,     40};
    vt[2]  = '{2'b01, 100,  40, 1'b0, 0,      100,    80};
    vt[3]  = '{2'b10, 100,  40, 1'b0, 0,      40,     180};
    vt[4]  = '{2'b00, 100,  40, 1'b0, 0,      32768,  220};
    vt[5]  = '{2'b11,   7,   7, 1'b0, 0,      7,      32988};
    vt[6]  = '{2'b11,   0,  50, 1'b0, 0,      0,      32995};
    vt[7]  = '{2'b11, 100, 100, 1'b1, 33000,  5,      32995};
    vt[8]  = '{2'b11,  20,  30, 1'b0, 0,      20,     33000};
    vt[9]  = '{2'b11,  20,  30, 1'b1, 10,     20,     33020};
    vt[10] = '{2'b00,  20,  30, 1'b1, 103040, 32768,  33040};
    vt[11] = '{2'b00,  20,  30, 1'b1, 66808,  1000,   65808};
    vt[12] = '{2'b11,   3,   9, 1'b0, 0,      3,      66808};

    go = 0; halt = 0; stop_en = 0; stop_time = 0;
    set_req(2'b11, 100, 40);
    go8 = 0; halt8 = 0; stop_en8 = 0; stop_time8 = 0;
    bus8.req_active = 2'b11; bus8.emu_dt_req = {8'd250, 8'd250};
`ifdef EMU_TIME_MGR_DT_LIMIT_EN
    dt_limit = 0; dt_limit8 = 0;
`endif

    // reset state
    emu_rst = 1'b1;
    tick(); tick();
    emu_rst = 1'b0;
    #1;
    chk("rst_time",     bus.emu_time, 0);
    chk("rst_state",    64'(state),   0);
    chk("rst_stop_hit", 64'(stop_hit), 0);
    chk("halt_dt",      64'(bus.emu_dt), 0);

    // 8-bit time wrap: 250 + 10 -> 4
    go8 = 1'b1; tick(); go8 = 1'b0; #1;
    chk("w8_dt250", 64'(bus8.emu_dt), 250);
    tick();
    chk("w8_time250", 64'(bus8.emu_time), 250);
    bus8.emu_dt_req = {8'd10, 8'd10}; #1;
    chk("w8_dt10", 64'(bus8.emu_dt), 10);
    tick();
    chk("w8_wrap", 64'(bus8.emu_time), 4);
    halt8 = 1'b1; tick(); halt8 = 1'b0;

    // grant table, from time 0 in RUN
    do_reset();
    pulse_go();
    for (int i = 0; i < 13; i++) begin
      set_req(vt[i].act, vt[i].r0, vt[i].r1);
      stop_en   = vt[i].sen;
      stop_time = vt[i].st;
      #1;
      chk($sformatf("vec%0d_dt", i),   64'(bus.emu_dt), vt[i].dt);
      chk($sformatf("vec%0d_time", i), bus.emu_time,    vt[i].tm);
      tick();
    end
    chk("vec_end_time", bus.emu_time, 66811);

    // stop boundary at 250 with requests of 100
    stop_en = 0;
    do_reset();
    pulse_go();
    set_req(2'b11, 100, 100); stop_en = 1'b1; stop_time = 250; #1;
    chk("stp_dt0", 64'(bus.emu_dt), 100);
    tick();
    chk("stp_dt1", 64'(bus.emu_dt), 100);
    tick();
    chk("stp_dt2", 64'(bus.emu_dt), 50);
    tick();
    chk("stp_time250", bus.emu_time, 250);
    chk("stp_dt_zero", 64'(bus.emu_dt), 0);
    chk("stp_still_run", 64'(state), 1);
    chk("stp_hit_early", 64'(stop_hit), 0);
    tick();
    chk("stp_state", 64'(state), 2);
    chk("stp_hit", 64'(stop_hit), 1);
    chk("stp_dt_stopped", 64'(bus.emu_dt), 0);
    stop_en = 1'b0;
    tick();
    chk("stp_hit_once", 64'(stop_hit), 0);
    chk("stp_hold_time", bus.emu_time, 250);
    tick();
    chk("stp_stays_stopped", 64'(state), 2);
    pulse_go(); #1;
    chk("resume_state", 64'(state), 1);
    chk("resume_dt", 64'(bus.emu_dt), 100);
    chk("resume_time", bus.emu_time, 250);

    // go while running is ignored
    pulse_go(); #1;
    chk("go_in_run_state", 64'(state), 1);
    chk("go_in_run_time", bus.emu_time, 350);

    // halt beats go
    go = 1'b1; halt = 1'b1;
    tick();
    go = 1'b0; halt = 1'b0; #1;
    chk("halt_prio_state", 64'(state), 0);
    chk("halt_prio_dt", 64'(bus.emu_dt), 0);
    chk("halt_prio_time", bus.emu_time, 450);
    tick();
    chk("halt_frozen", bus.emu_time, 450);

    // reset mid-run at time 1000
    pulse_go();
    do_reset();
    pulse_go();
    set_req(2'b11, 500, 500);
    tick(); tick();
    chk("mid_time1000", bus.emu_time, 1000);
    chk("mid_run", 64'(state), 1);
    emu_rst = 1'b1; go = 1'b1;
    tick();
    emu_rst = 1'b0; go = 1'b0; #1;
    chk("mid_rst_time", bus.emu_time, 0);
    chk("mid_rst_state", 64'(state), 0);
    chk("mid_rst_dt", 64'(bus.emu_dt), 0);

`ifdef EMU_TIME_MGR_DT_LIMIT_EN
    pulse_go();
    set_req(2'b11, 40, 40);
    dt_limit = 7; #1;
    chk("lim7_dt", 64'(bus.emu_dt), 7);
    dt_limit = 0; #1;
    chk("lim0_dt", 64'(bus.emu_dt), 40);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/emu_time_mgr.md
Name: emu_time_mgr

Overview:
- Responder side of the timestep request protocol.
- Collects `emu_dt_req` from N_REQ oscillator/event models. Each cycle it broadcasts the granted timestep `emu_dt`, which is the minimum of the active requests, optionally capped by a stop-time boundary.
- Owns the wide global emulation time counter and a run/halt/stop control FSM.
- Sits at the emulator top, between all requesters and the host control/debug registers.

Parameters:
- N_REQ, 2, number of requesters.
- DT_WIDTH, `DT_WIDTH, width of each timestep request and of the grant.
- TIME_WIDTH, 64, width of the global emulation time counter; must be >= DT_WIDTH.
- DT_IDLE, 2**(DT_WIDTH-1), grant value used when no requester is active.

Ports:
- emu_clk  in  1  emulator clock.
- emu_rst  in  1  synchronous, active-high reset.
- emu_dt_req  in  N_REQ*DT_WIDTH  flattened requests; requester i occupies bits [i*DT_WIDTH +: DT_WIDTH].
- req_active  in  N_REQ  per-requester enable; inactive requests are ignored.
- go  in  1  pulse: HALT or STOPPED -> RUN.
- halt  in  1  pulse: any state -> HALT.
- stop_en  in  1  enables the stop-time boundary.
- stop_time  in  TIME_WIDTH  absolute emulation time at which to stop.
- emu_dt  out  DT_WIDTH  granted timestep, combinational in the same cycle.
- emu_time  out  TIME_WIDTH  registered global time.
- state  out  2  0 = HALT, 1 = RUN, 2 = STOPPED.
- stop_hit  out  1  one-cycle pulse on RUN -> STOPPED.

Behaviour:
- Reset values: emu_time = 0, state = HALT, stop_hit = 0. The emu_dt grant is 0 while in HALT.
- Grant latency:
  - emu_dt is zero-latency combinational from emu_dt_req, req_active, emu_time and the current state.
  - Requesters compare their request against the grant in the same cycle, so no register may be inserted on this path.
- Grant rule, in RUN only:
  - m = unsigned minimum over active requests; m = DT_IDLE if none are active.
  - If stop_en = 1: d = stop_time - emu_time, computed modulo 2^TIME_WIDTH and saturated to 2^DT_WIDTH - 1. Then emu_dt = min(m, d).
  - Otherwise emu_dt = m.
- Grant in HALT and STOPPED: emu_dt = 0. Requesters see no tick and time freezes.
- Time update:
  - Every cycle, emu_time <= emu_time + emu_dt, modulo 2^TIME_WIDTH.
  - A zero request is legal and yields zero advance that cycle.
- FSM transitions, evaluated in priority order:
  - halt -> HALT, from any state. halt wins over a simultaneous go.
  - HALT or STOPPED with go -> RUN.
  - RUN with stop_en and emu_time == stop_time -> STOPPED, with stop_hit = 1 for one cycle. The grant that cycle is already 0 because d = 0.
- Boundary conditions:
  - stop_time below emu_time (modular): d wraps to a large value, so running continues until wrap. Software is responsible for programming stop_time ahead of time.
  - go while already in RUN: ignored.
  - emu_rst asserted mid-RUN: next cycle is the reset state regardless of other inputs.
  - stop_en deasserted in STOPPED: the state stays STOPPED until go.
- Ties: equal minima produce the same grant value, so no arbitration is needed.

Optional Feature:
- Macro: EMU_TIME_MGR_DT_LIMIT_EN.
- When defined:
  - Adds input port dt_limit (DT_WIDTH).
  - In RUN, emu_dt is further clamped to min(emu_dt, dt_limit).
  - dt_limit = 0 is treated as "no limit".
- When undefined: no dt_limit port and no clamp logic.

Decomposition:
- Package emu_time_mgr_pkg holds:
  - the state enum (HALT, RUN, STOPPED);
  - the state encoding width;
  - a helper function for the saturating TIME_WIDTH-to-DT_WIDTH narrowing.
- Sub-module dt_min_tree: purely combinational, parameterized by N_REQ and DT_WIDTH. It is a balanced binary reduction of masked requests; inactive inputs are forced to all-ones, and it also outputs an any_active flag.
- Time register, FSM and stop logic stay in emu_time_mgr.

Test Plan:
- Min grant: N_REQ = 2, both active, requests 100 and 40, state RUN -> emu_dt = 40; emu_time goes 0 -> 40 -> 80.
- Masking: req_active = 2'b01 with requests 100 and 40 -> emu_dt = 100. req_active = 0 -> emu_dt = DT_IDLE.
- Stop boundary: stop_en = 1, stop_time = 250, both requests 100 from time 0:
  - grants are 100, 100, 50;
  - emu_time reaches 250; the next cycle gives emu_dt = 0, stop_hit pulses once and state = STOPPED;
  - a later go with stop_en = 0 resumes with emu_dt = 100.
- Halt priority: go and halt asserted in the same cycle during RUN -> state = HALT, emu_dt = 0, emu_time frozen.
- Reset mid-run: emu_time = 1000 in RUN, emu_rst held for one cycle -> emu_time = 0, state = HALT, emu_dt = 0.
- Wrap and limit:
  - TIME_WIDTH = 8 at emu_time = 250 with emu_dt = 10 -> emu_time = 4.
  - With EMU_TIME_MGR_DT_LIMIT_EN, dt_limit = 7 and requests 40 -> emu_dt = 7.
